// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling constants and
// the baud-tick divisor helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } TRxState;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 8;
  localparam int DATA_BITS  = 8;

  // Clocks per oversample tick, truncated (27 at 50 MHz / 115200 baud).
  function automatic int uart_div(input int clk_freq, input int baud);
    return clk_freq / (baud * OVERSAMPLE);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous level input; resets to 1 so an
// idle-high line never looks like an edge when reset is released.
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver with 16x oversampling, mid-bit sampling and a one-entry holding
// register. Define UART_RX_PARITY_EN for 8E1 frames with an even parity check.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rx,
  output logic [7:0] data_out,
  output logic       data_ready,
  input  logic       data_rd,
  output logic       frame_err,
  output logic       overrun_err,
  output logic       parity_err,
  output logic       busy_rx
);

  // Handshake: data_ready is a level that stays high until the consumer pulses
  // data_rd for one clock; a frame completing in that same clock wins and keeps
  // data_ready high. Error outputs are single-clock pulses.

  localparam int DIV = uart_div(CLK_FREQ, BAUD);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(DIV - 1);
  localparam logic [3:0]    SAMP_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0]    MID_LAST  = 4'(MID_SAMPLE - 1);
  localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
  localparam TRxState AFTER_DATA = PARITY;
`else
  localparam TRxState AFTER_DATA = STOP;
`endif

  TRxState       state;
  logic          rx_s;
  logic          rx_prev;
  logic          start_edge;
  logic [CW-1:0] tick_cnt;
  logic          tick;
  logic [3:0]    samp_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_reg;

  uart_rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (uart_rx),
    .q     (rx_s)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rx_prev <= 1'b1;
    else        rx_prev <= rx_s;
  end

  assign start_edge = rx_prev & ~rx_s;
  assign tick       = (tick_cnt == TICK_LAST);
  assign busy_rx    = (state != IDLE);

  // Restarting the divider on the start edge puts every tick at a fixed phase
  // from the edge, so the 8th tick lands mid-bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                          tick_cnt <= '0;
    else if (state == IDLE && start_edge) tick_cnt <= '0;
    else if (tick)                       tick_cnt <= '0;
    else                                 tick_cnt <= tick_cnt + 1'b1;
  end

`ifdef UART_RX_PARITY_EN
  logic par_bad;
`else
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      samp_cnt    <= '0;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      data_out    <= '0;
      data_ready  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad     <= 1'b0;
      parity_err  <= 1'b0;
`endif
    end else begin
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err  <= 1'b0;
`endif
      if (data_rd && data_ready) data_ready <= 1'b0;

      case (state)
        IDLE: begin
          if (start_edge) begin
            state    <= START;
            samp_cnt <= '0;
          end
        end

        START: begin
          if (tick) begin
            if (samp_cnt == MID_LAST) begin
              samp_cnt <= '0;
              bit_cnt  <= '0;
              state    <= rx_s ? IDLE : DATA;
            end else begin
              samp_cnt <= samp_cnt + 4'd1;
            end
          end
        end

        DATA: begin
          if (tick) begin
            samp_cnt <= samp_cnt + 4'd1;
            if (samp_cnt == SAMP_LAST) begin
              shift_reg <= {rx_s, shift_reg[7:1]};
              if (bit_cnt == BIT_LAST) state   <= AFTER_DATA;
              else                     bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick) begin
            samp_cnt <= samp_cnt + 4'd1;
            if (samp_cnt == SAMP_LAST) begin
              par_bad <= ^{shift_reg, rx_s};
              state   <= STOP;
            end
          end
        end
`endif

        STOP: begin
          if (tick) begin
            samp_cnt <= samp_cnt + 4'd1;
            if (samp_cnt == SAMP_LAST) begin
              // Leave mid-stop so the next start edge can be caught early.
              if (!rx_s) begin
                frame_err <= 1'b1;
                state     <= BREAK;
              end
`ifdef UART_RX_PARITY_EN
              else if (par_bad) begin
                parity_err <= 1'b1;
                state      <= IDLE;
              end
`endif
              else begin
                data_out    <= shift_reg;
                data_ready  <= 1'b1;
                overrun_err <= data_ready && !data_rd;
                state       <= IDLE;
              end
            end
          end
        end

        BREAK: begin
          if (rx_s) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
